// File: rtl/relogio_pkg.sv
// ============================================================================
// Module   : relogio_pkg
// Brief    : Shared mode encoding, limits and widths for the clock datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package relogio_pkg;

    typedef enum logic [1:0] {
        MODO_RUN   = 2'd0,
        MODO_SET_H = 2'd1,
        MODO_SET_M = 2'd2
    } modo_e;

    localparam int MAX_MIN  = 59;
    localparam int MAX_HORA = 23;
    localparam int W_MIN    = 6;
    localparam int W_HORA   = 5;

endpackage

`default_nettype wire

// File: rtl/minutos_horas_if.sv
// ============================================================================
// Module   : minutos_horas_if
// Brief    : Button/pulse inputs and time outputs of the minute/hour stage.
//            Alarm signals exist only with RELOGIO_ALARME_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface minutos_horas_if;
    import relogio_pkg::*;

    logic               inc_min_i;
    logic               set_i;
    logic               up_i;
    logic [W_MIN-1:0]   minutos_o;
    logic [W_HORA-1:0]  horas_o;
    modo_e              modo_o;
    logic               inc_dia_o;
`ifdef RELOGIO_ALARME_EN
    logic [W_HORA-1:0]  alarme_h_i;
    logic [W_MIN-1:0]   alarme_m_i;
    logic               alarme_o;

    modport master (
        output inc_min_i, set_i, up_i, alarme_h_i, alarme_m_i,
        input  minutos_o, horas_o, modo_o, inc_dia_o, alarme_o
    );
    modport slave (
        input  inc_min_i, set_i, up_i, alarme_h_i, alarme_m_i,
        output minutos_o, horas_o, modo_o, inc_dia_o, alarme_o
    );
`else
    modport master (
        output inc_min_i, set_i, up_i,
        input  minutos_o, horas_o, modo_o, inc_dia_o
    );
    modport slave (
        input  inc_min_i, set_i, up_i,
        output minutos_o, horas_o, modo_o, inc_dia_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/contador_mod.sv
// ============================================================================
// Module   : contador_mod
// Brief    : Modulo-N enabled counter; wrap_o flags the enabled step at max.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_mod #(
    parameter int MODULO = 60,
    parameter int WIDTH  = 6
) (
    input  wire logic             clk_1Hz,
    input  wire logic             rstn_i,
    input  wire logic             en_i,
    output logic [WIDTH-1:0]      cnt_o,
    output logic                  wrap_o
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] r_cnt;

    assign wrap_o = en_i && (r_cnt == c_MAX);
    assign cnt_o  = r_cnt;

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= wrap_o ? '0 : r_cnt + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/minutos_horas.sv
// ============================================================================
// Module   : minutos_horas
// Brief    : Minute/hour counters with RUN/SET_H/SET_M mode FSM and a
//            day-rollover pulse. Optional alarm match under RELOGIO_ALARME_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module minutos_horas
    import relogio_pkg::*;
(
    input  wire logic         clk_1Hz,
    input  wire logic         rstn_i,
    minutos_horas_if.slave    bus
);

    modo_e              r_modo;
    logic               r_inc_dia;
    logic [W_MIN-1:0]   w_minutos;
    logic [W_HORA-1:0]  w_horas;
    logic               w_min_wrap;
    logic               w_hora_wrap;
    logic               w_run;
    logic               w_set_h;
    logic               w_set_m;
    logic               w_min_en;
    logic               w_hora_en;

    assign w_run   = (r_modo == MODO_RUN);
    assign w_set_h = (r_modo == MODO_SET_H);
    assign w_set_m = (r_modo == MODO_SET_M);

    // set_i has priority over up_i; inc_min_i counts only in RUN, even with set_i.
    assign w_min_en  = (w_run && bus.inc_min_i) || (w_set_m && bus.up_i && !bus.set_i);
    assign w_hora_en = (w_run && w_min_wrap)    || (w_set_h && bus.up_i && !bus.set_i);

    contador_mod #(
        .MODULO (MAX_MIN + 1),
        .WIDTH  (W_MIN)
    ) u_minutos (
        .clk_1Hz (clk_1Hz),
        .rstn_i  (rstn_i),
        .en_i    (w_min_en),
        .cnt_o   (w_minutos),
        .wrap_o  (w_min_wrap)
    );

    contador_mod #(
        .MODULO (MAX_HORA + 1),
        .WIDTH  (W_HORA)
    ) u_horas (
        .clk_1Hz (clk_1Hz),
        .rstn_i  (rstn_i),
        .en_i    (w_hora_en),
        .cnt_o   (w_horas),
        .wrap_o  (w_hora_wrap)
    );

`ifdef RELOGIO_ALARME_EN
    logic r_alarme;
    assign bus.alarme_o = r_alarme;
`endif

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_modo    <= MODO_RUN;
            r_inc_dia <= 1'b0;
`ifdef RELOGIO_ALARME_EN
            r_alarme  <= 1'b0;
`endif
        end else begin
            // Hour wrap in RUN only: manual hour edits never signal a new day.
            r_inc_dia <= w_run && w_hora_wrap;
            case (r_modo)
                MODO_RUN:   if (bus.set_i) r_modo <= MODO_SET_H;
                MODO_SET_H: if (bus.set_i) r_modo <= MODO_SET_M;
                MODO_SET_M: if (bus.set_i) r_modo <= MODO_RUN;
                default:    r_modo <= MODO_RUN;
            endcase
`ifdef RELOGIO_ALARME_EN
            r_alarme <= w_run && (w_horas == bus.alarme_h_i) && (w_minutos == bus.alarme_m_i);
`endif
        end
    end

    assign bus.minutos_o = w_minutos;
    assign bus.horas_o   = w_horas;
    assign bus.modo_o    = r_modo;
    assign bus.inc_dia_o = r_inc_dia;

endmodule

`default_nettype wire
